// File: rtl/pcie_trans_param_if.sv
// Bus bundle for the parametrised transaction-layer buffer: link-side push,
// per-channel pop/data, threshold programming, counter readback and status.
interface pcie_trans_param_if #(
    parameter int DATA_W = 12,
    parameter int CH_W   = 2,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 5
);
    localparam int CH = 2 ** CH_W;

    logic                   init;
    logic [ADDR_W:0]        umbral_L;
    logic [ADDR_W:0]        umbral_H;
    logic                   push;
    logic [DATA_W-1:0]      data_in;
    logic                   full;
    logic [CH-1:0]          pop;
    logic [CH*DATA_W-1:0]   data_out;
    logic [CH-1:0]          data_valid;
    logic [CH-1:0]          empty;
    logic [CH-1:0]          almost_full;
    logic [CH-1:0]          almost_empty;
    logic                   req;
    logic [CH_W-1:0]        idx;
    logic [CNT_W-1:0]       cnt_out;
    logic                   cnt_valid;
    logic [4:0]             state;
    logic                   error;

    modport master (
        output init, umbral_L, umbral_H, push, data_in, pop, req, idx,
        input  full, data_out, data_valid, empty, almost_full, almost_empty,
               cnt_out, cnt_valid, state, error
    );

    modport slave (
        input  init, umbral_L, umbral_H, push, data_in, pop, req, idx,
        output full, data_out, data_valid, empty, almost_full, almost_empty,
               cnt_out, cnt_valid, state, error
    );
endinterface

// File: rtl/pcie_trans_param.sv
// Parametrised transaction-layer buffer. One input FIFO feeds 2**CH_W output
// FIFOs selected by the top CH_W bits of each word. The input head only moves
// while the FSM is ACTIVE and its destination is not almost full, so a blocked
// head stalls every channel. Illegal push/pop sends the FSM to a sticky ERROR.
module pcie_trans_param #(
    parameter int DATA_W = 12,
    parameter int CH_W   = 2,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 5
) (
    input  logic                clk,
    input  logic                reset,
    pcie_trans_param_if.slave   bus
);
    localparam int CH    = 2 ** CH_W;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] OCC_ZERO = {(ADDR_W+1){1'b0}};

    typedef enum logic [4:0] {
        ST_RESET  = 5'b00001,
        ST_INIT   = 5'b00010,
        ST_IDLE   = 5'b00100,
        ST_ACTIVE = 5'b01000,
        ST_ERROR  = 5'b10000
    } state_t;

    state_t                 state_r;
    logic                   error_r;
    logic [ADDR_W:0]        thr_l_r;
    logic [ADDR_W:0]        thr_h_r;

    logic [DATA_W-1:0]      in_mem_r [DEPTH];
    logic [ADDR_W-1:0]      in_wr_r;
    logic [ADDR_W-1:0]      in_rd_r;
    logic [ADDR_W:0]        in_cnt_r;

    logic [DATA_W-1:0]      ch_mem_r [CH][DEPTH];
    logic [ADDR_W-1:0]      ch_wr_r  [CH];
    logic [ADDR_W-1:0]      ch_rd_r  [CH];
    logic [ADDR_W:0]        ch_cnt_r [CH];

    logic [CNT_W-1:0]       pop_cnt_r [CH];
    logic [CH*DATA_W-1:0]   data_out_r;
    logic [CH-1:0]          data_valid_r;
    logic [CNT_W-1:0]       cnt_out_r;
    logic                   cnt_valid_r;

    logic                   full_s;
    logic [CH-1:0]          empty_s;
    logic [CH-1:0]          af_s;
    logic [CH-1:0]          ae_s;
    logic [CH-1:0]          pop_ok_s;
    logic [CH-1:0]          ch_wr_en_s;
    logic                   push_ok_s;
    logic                   fwd_s;
    logic                   err_s;
    logic                   all_empty_s;
    logic [DATA_W-1:0]      head_s;
    logic [CH_W-1:0]        head_sel_s;

    // Status flags, forwarding decision and error detection from registered occupancy
    always_comb begin
        full_s     = (in_cnt_r == DEPTH_C);
        head_s     = in_mem_r[in_rd_r];
        head_sel_s = head_s[DATA_W-1 -: CH_W];
        for (int i = 0; i < CH; i++) begin
            empty_s[i] = (ch_cnt_r[i] == OCC_ZERO);
            af_s[i]    = (ch_cnt_r[i] >= thr_h_r);
            ae_s[i]    = (ch_cnt_r[i] <= thr_l_r);
        end
        all_empty_s = (in_cnt_r == OCC_ZERO) && (&empty_s);
        push_ok_s   = bus.push && !full_s &&
                      ((state_r == ST_INIT) || (state_r == ST_IDLE) || (state_r == ST_ACTIVE));
        fwd_s       = (state_r == ST_ACTIVE) && (in_cnt_r != OCC_ZERO) && !af_s[head_sel_s];
        for (int i = 0; i < CH; i++) begin
            ch_wr_en_s[i] = fwd_s && (head_sel_s == CH_W'(i));
            pop_ok_s[i]   = bus.pop[i] && !empty_s[i] && (state_r != ST_ERROR);
        end
        err_s = (state_r != ST_RESET) &&
                ((bus.push && full_s) || ((bus.pop & empty_s) != {CH{1'b0}}));
    end

    assign bus.full         = full_s;
    assign bus.empty        = empty_s;
    assign bus.almost_full  = af_s;
    assign bus.almost_empty = ae_s;
    assign bus.data_out     = data_out_r;
    assign bus.data_valid   = data_valid_r;
    assign bus.cnt_out      = cnt_out_r;
    assign bus.cnt_valid    = cnt_valid_r;
    assign bus.state        = state_r;
    assign bus.error        = error_r;

    // Control FSM; init has priority over traffic-driven moves, ERROR only leaves on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_RESET;
            error_r <= 1'b0;
        end else begin
            error_r <= 1'b0;
            case (state_r)
                ST_RESET: state_r <= ST_INIT;
                ST_INIT: begin
                    if (err_s) begin
                        state_r <= ST_ERROR;
                        error_r <= 1'b1;
                    end else if (!bus.init) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_INIT;
                    end
                end
                ST_IDLE: begin
                    if (err_s) begin
                        state_r <= ST_ERROR;
                        error_r <= 1'b1;
                    end else if (bus.init) begin
                        state_r <= ST_INIT;
                    end else if (bus.push) begin
                        state_r <= ST_ACTIVE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACTIVE: begin
                    if (err_s) begin
                        state_r <= ST_ERROR;
                        error_r <= 1'b1;
                    end else if (bus.init) begin
                        state_r <= ST_INIT;
                    end else if (all_empty_s && !bus.push) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_ACTIVE;
                    end
                end
                ST_ERROR: begin
                    state_r <= ST_ERROR;
                    error_r <= 1'b1;
                end
                default: begin
                    state_r <= ST_ERROR;
                    error_r <= 1'b1;
                end
            endcase
        end
    end

    // Threshold registers, reloaded every edge spent in INIT with init held high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            thr_l_r <= OCC_ZERO;
            thr_h_r <= DEPTH_C;
        end else if ((state_r == ST_INIT) && bus.init) begin
            thr_l_r <= bus.umbral_L;
            thr_h_r <= bus.umbral_H;
        end
    end

    // Input FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_wr_r  <= {ADDR_W{1'b0}};
            in_rd_r  <= {ADDR_W{1'b0}};
            in_cnt_r <= OCC_ZERO;
        end else begin
            if (push_ok_s) begin
                in_wr_r <= in_wr_r + ADDR_W'(1);
            end
            if (fwd_s) begin
                in_rd_r <= in_rd_r + ADDR_W'(1);
            end
            in_cnt_r <= in_cnt_r + (ADDR_W+1)'(push_ok_s) - (ADDR_W+1)'(fwd_s);
        end
    end

    // Input FIFO storage; contents are don't-care once the pointers are reset
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            in_mem_r[in_wr_r] <= bus.data_in;
        end
    end

    // Channel FIFO storage, written by the forwarded input head
    always_ff @(posedge clk) begin
        for (int i = 0; i < CH; i++) begin
            if (ch_wr_en_s[i]) begin
                ch_mem_r[i][ch_wr_r[i]] <= head_s;
            end
        end
    end

    // Channel FIFO pointers and occupancy; a forward and pop in one cycle cancel out
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CH; i++) begin
                ch_wr_r[i]  <= {ADDR_W{1'b0}};
                ch_rd_r[i]  <= {ADDR_W{1'b0}};
                ch_cnt_r[i] <= OCC_ZERO;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (ch_wr_en_s[i]) begin
                    ch_wr_r[i] <= ch_wr_r[i] + ADDR_W'(1);
                end
                if (pop_ok_s[i]) begin
                    ch_rd_r[i] <= ch_rd_r[i] + ADDR_W'(1);
                end
                ch_cnt_r[i] <= ch_cnt_r[i] + (ADDR_W+1)'(ch_wr_en_s[i]) - (ADDR_W+1)'(pop_ok_s[i]);
            end
        end
    end

    // Registered pop data: slice updates and valid pulses only on a successful pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_r   <= {(CH*DATA_W){1'b0}};
            data_valid_r <= {CH{1'b0}};
        end else begin
            for (int i = 0; i < CH; i++) begin
                data_valid_r[i] <= pop_ok_s[i];
                if (pop_ok_s[i]) begin
                    data_out_r[i*DATA_W +: DATA_W] <= ch_mem_r[i][ch_rd_r[i]];
                end
            end
        end
    end

    // Per-channel pop counters (wrap naturally) and readback; a read sees the pre-increment value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CH; i++) begin
                pop_cnt_r[i] <= {CNT_W{1'b0}};
            end
            cnt_out_r   <= {CNT_W{1'b0}};
            cnt_valid_r <= 1'b0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                pop_cnt_r[i] <= pop_cnt_r[i] + CNT_W'(pop_ok_s[i]);
            end
            if (bus.req) begin
                cnt_out_r   <= pop_cnt_r[bus.idx];
                cnt_valid_r <= 1'b1;
            end else begin
                cnt_out_r   <= {CNT_W{1'b0}};
                cnt_valid_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pcie_trans_param.sv
// Testbench for pcie_trans_param: directed scenarios plus randomized traffic
// checked against a queue-based model of the buffer.
module tb_pcie_trans_param;
    localparam int DATA_W = 12;
    localparam int CH_W   = 2;
    localparam int ADDR_W = 3;
    localparam int CNT_W  = 5;
    localparam int CH     = 4;
    localparam int DEPTH  = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    pcie_trans_param_if #(.DATA_W(DATA_W), .CH_W(CH_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus();

    pcie_trans_param #(.DATA_W(DATA_W), .CH_W(CH_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.init = 1'b0; bus.push = 1'b0; bus.data_in = 12'h000;
        bus.pop = 4'b0000; bus.req = 1'b0; bus.idx = 2'd0;
        bus.umbral_L = 4'd0; bus.umbral_H = 4'd8;
    endtask

    // reset, then INIT with the given thresholds, then IDLE
    task automatic bring_up(input logic [3:0] l, input logic [3:0] h);
        idle_inputs();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        step();
        bus.init = 1'b1; bus.umbral_L = l; bus.umbral_H = h;
        step();
        bus.init = 1'b0;
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        step(); step();
        n_checks++;
        if (bus.state !== 5'b00001 || bus.error !== 1'b0 || bus.full !== 1'b0) begin
            n_fail++; $display("FAIL reset_state: got state=%b error=%b full=%b, expected 00001 0 0", bus.state, bus.error, bus.full);
        end
        n_checks++;
        if (bus.empty !== 4'hF || bus.almost_empty !== 4'hF || bus.almost_full !== 4'h0) begin
            n_fail++; $display("FAIL reset_flags: got empty=%b ae=%b af=%b, expected 1111 1111 0000", bus.empty, bus.almost_empty, bus.almost_full);
        end
        n_checks++;
        if (bus.data_out !== 48'h0 || bus.data_valid !== 4'h0 || bus.cnt_out !== 5'd0 || bus.cnt_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs: got dout=%h dv=%b cnt=%0d cv=%b, expected all 0", bus.data_out, bus.data_valid, bus.cnt_out, bus.cnt_valid);
        end
        reset = 1'b0;
        step();
        n_checks++;
        if (bus.state !== 5'b00010) begin
            n_fail++; $display("FAIL reset_to_init: got %b expected 00010", bus.state);
        end
        bus.init = 1'b1; bus.umbral_L = 4'd1; bus.umbral_H = 4'd6;
        step();
        n_checks++;
        if (bus.state !== 5'b00010) begin
            n_fail++; $display("FAIL init_hold: got %b expected 00010", bus.state);
        end
        bus.init = 1'b0;
        step();
        n_checks++;
        if (bus.state !== 5'b00100 || bus.empty !== 4'hF || bus.almost_empty !== 4'hF) begin
            n_fail++; $display("FAIL init_to_idle: got state=%b empty=%b ae=%b, expected 00100 1111 1111", bus.state, bus.empty, bus.almost_empty);
        end
    endtask

    task automatic test_routing();
        logic [11:0] words [4];
        words[0] = 12'h005; words[1] = 12'h40A; words[2] = 12'h80F; words[3] = 12'hC01;
        for (int c = 0; c < CH; c++) begin
            bus.push = 1'b1; bus.data_in = words[c];
            step();
            bus.push = 1'b0;
            step();
            n_checks++;
            if (bus.empty !== (4'hF & ~(4'b0001 << c)) || bus.data_valid !== 4'b0000) begin
                n_fail++; $display("FAIL route_fwd_ch%0d: got empty=%b dv=%b, expected %b 0000", c, bus.empty, bus.data_valid, 4'hF & ~(4'b0001 << c));
            end
            bus.pop = 4'b0001 << c;
            step();
            bus.pop = 4'b0000;
            n_checks++;
            if (bus.data_valid !== (4'b0001 << c) || bus.data_out[c*DATA_W +: DATA_W] !== words[c]) begin
                n_fail++; $display("FAIL route_pop_ch%0d: got dv=%b data=%h, expected %b %h", c, bus.data_valid, bus.data_out[c*DATA_W +: DATA_W], 4'b0001 << c, words[c]);
            end
            step();
            n_checks++;
            if (bus.data_valid !== 4'b0000) begin
                n_fail++; $display("FAIL route_dv_pulse_ch%0d: got %b expected 0000", c, bus.data_valid);
            end
        end
        for (int c = 0; c < CH; c++) begin
            bus.req = 1'b1; bus.idx = 2'(c);
            step();
            n_checks++;
            if (bus.cnt_valid !== 1'b1 || bus.cnt_out !== 5'd1) begin
                n_fail++; $display("FAIL route_cnt_ch%0d: got valid=%b cnt=%0d, expected 1 1", c, bus.cnt_valid, bus.cnt_out);
            end
        end
        bus.req = 1'b0;
        step();
        n_checks++;
        if (bus.cnt_valid !== 1'b0 || bus.cnt_out !== 5'd0) begin
            n_fail++; $display("FAIL route_cnt_idle: got valid=%b cnt=%0d, expected 0 0", bus.cnt_valid, bus.cnt_out);
        end
    endtask

    task automatic test_hol();
        bring_up(4'd1, 4'd6);
        for (int k = 1; k <= 8; k++) begin
            bus.push = 1'b1; bus.data_in = 12'h800 | 12'(k);
            step();
            n_checks++;
            if (bus.almost_full[2] !== (k >= 7)) begin
                n_fail++; $display("FAIL hol_af_push%0d: got %b expected %b", k, bus.almost_full[2], k >= 7);
            end
        end
        bus.data_in = 12'h055;
        step();
        bus.push = 1'b0;
        step(); step(); step();
        n_checks++;
        if (bus.empty !== 4'b1011 || bus.almost_full !== 4'b0100 || bus.full !== 1'b0) begin
            n_fail++; $display("FAIL hol_blocked: got empty=%b af=%b full=%b, expected 1011 0100 0", bus.empty, bus.almost_full, bus.full);
        end
        for (int k = 1; k <= 5; k++) begin
            bus.push = 1'b1; bus.data_in = 12'h060 | 12'(k);
            step();
            n_checks++;
            if (bus.full !== (k == 5)) begin
                n_fail++; $display("FAIL hol_fill%0d: got full=%b expected %b", k, bus.full, k == 5);
            end
        end
        bus.push = 1'b0;
    endtask

    task automatic test_full_error();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        bus.init = 1'b1; bus.umbral_L = 4'd1; bus.umbral_H = 4'd6;
        for (int k = 1; k <= 8; k++) begin
            bus.push = 1'b1; bus.data_in = 12'(k);
            step();
            n_checks++;
            if (bus.full !== (k == 8) || bus.state !== 5'b00010) begin
                n_fail++; $display("FAIL full_push%0d: got full=%b state=%b, expected %b 00010", k, bus.full, bus.state, k == 8);
            end
        end
        bus.data_in = 12'h009;
        step();
        bus.push = 1'b0; bus.init = 1'b0;
        n_checks++;
        if (bus.state !== 5'b10000 || bus.error !== 1'b1) begin
            n_fail++; $display("FAIL full_overflow_err: got state=%b error=%b, expected 10000 1", bus.state, bus.error);
        end
        step(); step(); step();
        n_checks++;
        if (bus.state !== 5'b10000 || bus.error !== 1'b1) begin
            n_fail++; $display("FAIL full_err_sticky: got state=%b error=%b, expected 10000 1", bus.state, bus.error);
        end
        reset = 1'b1;
        #2;
        n_checks++;
        if (bus.state !== 5'b00001 || bus.error !== 1'b0 || bus.full !== 1'b0) begin
            n_fail++; $display("FAIL full_err_reset: got state=%b error=%b full=%b, expected 00001 0 0", bus.state, bus.error, bus.full);
        end
        step();
        reset = 1'b0;
    endtask

    task automatic test_pop_empty_error();
        bring_up(4'd1, 4'd6);
        bus.pop = 4'b0010;
        step();
        bus.pop = 4'b0000;
        n_checks++;
        if (bus.state !== 5'b10000 || bus.error !== 1'b1 || bus.data_valid[1] !== 1'b0) begin
            n_fail++; $display("FAIL pop_empty_err: got state=%b error=%b dv1=%b, expected 10000 1 0", bus.state, bus.error, bus.data_valid[1]);
        end
        step(); step();
        n_checks++;
        if (bus.error !== 1'b1 || bus.data_valid !== 4'b0000) begin
            n_fail++; $display("FAIL pop_empty_sticky: got error=%b dv=%b, expected 1 0000", bus.error, bus.data_valid);
        end
    endtask

    task automatic test_counter_wrap();
        bring_up(4'd1, 4'd6);
        for (int k = 1; k <= 35; k++) begin
            bus.push = (k <= 33); bus.data_in = 12'(k);
            bus.pop = (k >= 3) ? 4'b0001 : 4'b0000;
            bus.req = (k == 34); bus.idx = 2'd0;
            step();
            if (k >= 3) begin
                n_checks++;
                if (bus.data_valid !== 4'b0001 || bus.data_out[11:0] !== 12'(k - 2)) begin
                    n_fail++; $display("FAIL wrap_pop%0d: got dv=%b data=%h, expected 0001 %h", k - 2, bus.data_valid, bus.data_out[11:0], 12'(k - 2));
                end
            end
            if (k == 34) begin
                n_checks++;
                if (bus.cnt_valid !== 1'b1 || bus.cnt_out !== 5'd31) begin
                    n_fail++; $display("FAIL wrap_read_at_incr: got valid=%b cnt=%0d, expected 1 31", bus.cnt_valid, bus.cnt_out);
                end
            end
        end
        bus.push = 1'b0; bus.pop = 4'b0000; bus.req = 1'b1; bus.idx = 2'd0;
        step();
        bus.req = 1'b0;
        n_checks++;
        if (bus.cnt_valid !== 1'b1 || bus.cnt_out !== 5'd1) begin
            n_fail++; $display("FAIL wrap_final: got valid=%b cnt=%0d, expected 1 1", bus.cnt_valid, bus.cnt_out);
        end
    endtask

    // Random traffic against a queue model; mode 1=INIT, 2=IDLE, 3=ACTIVE
    task automatic test_random();
        logic [DATA_W-1:0] inq [$];
        logic [DATA_W-1:0] chq [CH][$];
        logic [CNT_W-1:0]  cnt_m [CH];
        logic [DATA_W-1:0] dout_m [CH];
        logic [CH*DATA_W-1:0] exp_dout;
        logic [CH-1:0] pv, exp_dv, exp_empty, exp_af, exp_ae;
        logic [DATA_W-1:0] w, d;
        logic [CNT_W-1:0] exp_cnt;
        logic [1:0] sel, ix;
        logic p, do_init, r, all_empty, fwd;
        int mode, thr_l, thr_h, l, h;
        thr_l = $urandom_range(0, 3);
        thr_h = $urandom_range(3, 8);
        bring_up(4'(thr_l), 4'(thr_h));
        mode = 2;
        for (int i = 0; i < CH; i++) begin
            cnt_m[i] = 5'd0; dout_m[i] = 12'h000;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            do_init = ($urandom_range(0, 24) == 0);
            p = !do_init && (inq.size() < DEPTH) && ($urandom_range(0, 2) != 0);
            d = 12'($urandom);
            for (int i = 0; i < CH; i++) pv[i] = (chq[i].size() > 0) && ($urandom_range(0, 2) == 0);
            r = $urandom_range(0, 1);
            ix = 2'($urandom_range(0, 3));
            l = $urandom_range(0, 4);
            h = $urandom_range(2, 8);
            bus.init = do_init; bus.push = p; bus.data_in = d; bus.pop = pv;
            bus.req = r; bus.idx = ix; bus.umbral_L = 4'(l); bus.umbral_H = 4'(h);
            // model of one clock edge
            all_empty = (inq.size() == 0);
            for (int i = 0; i < CH; i++) all_empty = all_empty && (chq[i].size() == 0);
            fwd = 1'b0;
            sel = 2'd0;
            if (mode == 3 && inq.size() > 0) begin
                w = inq[0];
                sel = w[DATA_W-1 -: CH_W];
                fwd = (chq[sel].size() < thr_h);
            end
            exp_cnt = r ? cnt_m[ix] : 5'd0;
            for (int i = 0; i < CH; i++) begin
                exp_dv[i] = pv[i];
                if (pv[i]) begin
                    dout_m[i] = chq[i].pop_front();
                    cnt_m[i] = cnt_m[i] + 5'd1;
                end
            end
            if (fwd) chq[sel].push_back(inq.pop_front());
            if (p) inq.push_back(d);
            if (mode == 1 && do_init) begin
                thr_l = l; thr_h = h;
            end
            case (mode)
                1: mode = do_init ? 1 : 2;
                2: mode = do_init ? 1 : (p ? 3 : 2);
                default: mode = do_init ? 1 : ((all_empty && !p) ? 2 : 3);
            endcase
            for (int i = 0; i < CH; i++) begin
                exp_dout[i*DATA_W +: DATA_W] = dout_m[i];
                exp_empty[i] = (chq[i].size() == 0);
                exp_af[i] = (chq[i].size() >= thr_h);
                exp_ae[i] = (chq[i].size() <= thr_l);
            end
            step();
            n_checks++;
            if (bus.state !== (5'b00001 << mode) || bus.error !== 1'b0 || bus.full !== (inq.size() == DEPTH)) begin
                n_fail++; $display("FAIL rand_state cyc%0d: got state=%b err=%b full=%b, expected %b 0 %b", cyc, bus.state, bus.error, bus.full, 5'b00001 << mode, inq.size() == DEPTH);
            end
            n_checks++;
            if (bus.empty !== exp_empty || bus.almost_full !== exp_af || bus.almost_empty !== exp_ae) begin
                n_fail++; $display("FAIL rand_flags cyc%0d: got e=%b af=%b ae=%b, expected %b %b %b", cyc, bus.empty, bus.almost_full, bus.almost_empty, exp_empty, exp_af, exp_ae);
            end
            n_checks++;
            if (bus.data_valid !== exp_dv || bus.data_out !== exp_dout) begin
                n_fail++; $display("FAIL rand_data cyc%0d: got dv=%b dout=%h, expected %b %h", cyc, bus.data_valid, bus.data_out, exp_dv, exp_dout);
            end
            n_checks++;
            if (bus.cnt_valid !== r || bus.cnt_out !== exp_cnt) begin
                n_fail++; $display("FAIL rand_cnt cyc%0d: got v=%b cnt=%0d, expected %b %0d", cyc, bus.cnt_valid, bus.cnt_out, r, exp_cnt);
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_routing();
        test_hol();
        test_full_error();
        test_pop_empty_error();
        test_counter_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
